// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the team FIFO: issues credit-limited reads, absorbs the
// FIFO read latency and presents the words as a valid/ready stream via a 2-entry buffer.
module fifo_stream_reader #(
    parameter int WIDTH     = 1,
    parameter bit FWFT      = 1'b0,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    output logic                 o_fifo_ren,
    input  logic                 i_fifo_empty,
    input  logic [WIDTH-1:0]     i_fifo_rdata,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_idle
);

    logic [1:0]           occ_r;
    logic [1:0]           occ_next_s;
    logic                 inflight_r;
    logic [WIDTH-1:0]     entry0_r;
    logic [WIDTH-1:0]     entry1_r;
    logic [WIDTH-1:0]     entry0_next_s;
    logic [WIDTH-1:0]     entry1_next_s;
    logic [CNT_WIDTH-1:0] count_r;
    logic [2:0]           credit_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 ren_s;

    assign pop_s = (occ_r != 2'd0) && i_ready;

    // Read issue: words already buffered or in flight, minus the one leaving now, must leave room.
    always_comb begin
        credit_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        ren_s    = 1'b0;
        if (!i_rst && i_en && !i_fifo_empty && (credit_s < 3'd2)) begin
            ren_s = 1'b1;
        end else begin
            ren_s = 1'b0;
        end
        if (FWFT) begin
            push_s = ren_s;
        end else begin
            push_s = inflight_r;
        end
    end

    // Buffer next state: entry 0 is always the oldest word.
    always_comb begin
        entry0_next_s = entry0_r;
        entry1_next_s = entry1_r;
        occ_next_s    = occ_r;
        case ({push_s, pop_s})
            2'b10: begin
                occ_next_s = occ_r + 2'd1;
                if (occ_r == 2'd0) begin
                    entry0_next_s = i_fifo_rdata;
                end else begin
                    entry1_next_s = i_fifo_rdata;
                end
            end
            2'b01: begin
                occ_next_s    = occ_r - 2'd1;
                entry0_next_s = entry1_r;
            end
            2'b11: begin
                if (occ_r == 2'd1) begin
                    entry0_next_s = i_fifo_rdata;
                end else begin
                    entry0_next_s = entry1_r;
                    entry1_next_s = i_fifo_rdata;
                end
            end
            default: begin
                occ_next_s = occ_r;
            end
        endcase
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            entry0_r   <= '0;
            entry1_r   <= '0;
            count_r    <= '0;
        end else begin
            occ_r      <= occ_next_s;
            inflight_r <= FWFT ? 1'b0 : ren_s;
            entry0_r   <= entry0_next_s;
            entry1_r   <= entry1_next_s;
            if (pop_s) begin
                count_r <= count_r + CNT_WIDTH'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign o_fifo_ren = ren_s;
    assign o_valid    = (occ_r != 2'd0);
    assign o_data     = entry0_r;
    assign o_count    = count_r;
    assign o_idle     = (occ_r == 2'd0) && !inflight_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FWFT=0 and FWFT=1 instances fed from queue-based FIFO
// models, with a word-order scoreboard plus directed timing checks.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, ready;
    logic ren0, ren1, empty0, empty1, valid0, valid1, idle0, idle1;
    logic [7:0] rd0, rd1, data0, data1;
    logic [31:0] cnt0, cnt1;

    fifo_stream_reader #(.WIDTH(8), .FWFT(1'b0), .CNT_WIDTH(32)) u0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .o_fifo_ren(ren0), .i_fifo_empty(empty0),
        .i_fifo_rdata(rd0), .o_valid(valid0), .i_ready(ready), .o_data(data0),
        .o_count(cnt0), .o_idle(idle0));

    fifo_stream_reader #(.WIDTH(8), .FWFT(1'b1), .CNT_WIDTH(32)) u1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .o_fifo_ren(ren1), .i_fifo_empty(empty1),
        .i_fifo_rdata(rd1), .o_valid(valid1), .i_ready(ready), .o_data(data1),
        .o_count(cnt1), .o_idle(idle1));

    logic [7:0] fq0[$], fq1[$], eq0[$], eq1[$];
    int tests = 0, fails = 0;
    int reads0 = 0, reads1 = 0, got0 = 0, got1 = 0;
    logic hold0 = 1'b0, hold1 = 1'b0;
    logic [7:0] hd0, hd1, s_dat0, s_dat1;
    logic s_ren0, s_ren1, s_val0, s_val1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        empty0 = (fq0.size() == 0);
        empty1 = (fq1.size() == 0);
        rd1    = (fq1.size() != 0) ? fq1[0] : 8'($urandom);
    endtask

    task automatic load(input logic [7:0] w);
        fq0.push_back(w); eq0.push_back(w);
        fq1.push_back(w); eq1.push_back(w);
        refresh();
    endtask

    // One clock: sample and score before the edge, then advance the FIFO models.
    task automatic tick();
        #1;
        s_ren0 = ren0; s_val0 = valid0; s_dat0 = data0;
        s_ren1 = ren1; s_val1 = valid1; s_dat1 = data1;
        chk("ren_while_empty0", 32'(ren0 & empty0), 32'd0);
        chk("ren_while_empty1", 32'(ren1 & empty1), 32'd0);
        if (hold0) begin
            chk("hold_valid0", 32'(valid0), 32'd1);
            chk("hold_data0", 32'(data0), 32'(hd0));
        end
        if (hold1) begin
            chk("hold_valid1", 32'(valid1), 32'd1);
            chk("hold_data1", 32'(data1), 32'(hd1));
        end
        if (valid0 && ready) begin
            if (eq0.size() == 0) chk("extra_word0", 32'(data0), 32'hFFFF_FFFF);
            else chk("data_order0", 32'(data0), 32'(eq0.pop_front()));
            got0++;
        end
        if (valid1 && ready) begin
            if (eq1.size() == 0) chk("extra_word1", 32'(data1), 32'hFFFF_FFFF);
            else chk("data_order1", 32'(data1), 32'(eq1.pop_front()));
            got1++;
        end
        hold0 = valid0 && !ready; hd0 = data0;
        hold1 = valid1 && !ready; hd1 = data1;
        @(posedge clk);
        #1;
        if (s_ren0 && fq0.size() != 0) begin
            reads0++;
            rd0 = fq0.pop_front();
        end else begin
            rd0 = 8'($urandom);
        end
        if (s_ren1 && fq1.size() != 0) begin
            reads1++;
            void'(fq1.pop_front());
        end
        refresh();
    endtask

    initial begin
        int b0, b1, g0, g1, n;
        rst = 1'b1; en = 1'b1; ready = 1'b0; rd0 = 8'h00;
        refresh();
        #2;
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_data0", 32'(data0), 32'd0);
        chk("rst_count0", cnt0, 32'd0);
        chk("rst_count1", cnt1, 32'd0);
        chk("rst_idle0", 32'(idle0), 32'd1);
        chk("rst_idle1", 32'(idle1), 32'd1);
        chk("rst_ren0", 32'(ren0), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Three words, full throughput: check exact issue and delivery cycles.
        load(8'h11); load(8'h22); load(8'h33);
        ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("t1_ren0", 32'(s_ren0), 32'(c < 3));
            chk("t1_ren1", 32'(s_ren1), 32'(c < 3));
            chk("t1_valid0", 32'(s_val0), 32'(c >= 2 && c <= 4));
            chk("t1_valid1", 32'(s_val1), 32'(c >= 1 && c <= 3));
            if (c >= 2 && c <= 4) chk("t1_data0", 32'(s_dat0), 32'(8'h11 * (c - 1)));
            if (c >= 1 && c <= 3) chk("t1_data1", 32'(s_dat1), 32'(8'h11 * c));
        end
        chk("t1_count0", cnt0, 32'd3);
        chk("t1_count1", cnt1, 32'd3);
        chk("t1_idle0", 32'(idle0), 32'd1);
        chk("t1_idle1", 32'(idle1), 32'd1);

        // Backpressure: only two reads issued, then gap-free drain.
        ready = 1'b0; b0 = reads0; b1 = reads1; g0 = got0; g1 = got1;
        for (int i = 0; i < 5; i++) load(8'($urandom));
        for (int i = 0; i < 6; i++) tick();
        chk("stall_reads0", 32'(reads0 - b0), 32'd2);
        chk("stall_reads1", 32'(reads1 - b1), 32'd2);
        chk("stall_head0", 32'(data0), 32'(eq0[0]));
        chk("stall_head1", 32'(data1), 32'(eq1[0]));
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nogap_valid0", 32'(s_val0), 32'd1);
            chk("nogap_valid1", 32'(s_val1), 32'd1);
        end
        for (int i = 0; i < 3; i++) tick();
        chk("stall_got0", 32'(got0 - g0), 32'd5);
        chk("stall_got1", 32'(got1 - g1), 32'd5);

        // Alternating ready with 20 words.
        b0 = cnt0; b1 = cnt1; g0 = got0; g1 = got1; n = 0;
        for (int i = 0; i < 20; i++) load(8'($urandom));
        while ((eq0.size() != 0 || eq1.size() != 0) && n < 200) begin
            ready = n[0] ? 1'b0 : 1'b1;
            tick();
            n++;
        end
        chk("tog_got0", 32'(got0 - g0), 32'd20);
        chk("tog_got1", 32'(got1 - g1), 32'd20);
        chk("tog_count0", cnt0 - b0, 32'd20);
        chk("tog_count1", cnt1 - b1, 32'd20);

        // Enable drop right after the first read.
        ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        b0 = reads0; b1 = reads1; g0 = got0; g1 = got1;
        for (int i = 0; i < 4; i++) load(8'($urandom));
        tick();
        en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("endrop_reads0", 32'(reads0 - b0), 32'd1);
        chk("endrop_reads1", 32'(reads1 - b1), 32'd1);
        chk("endrop_got0", 32'(got0 - g0), 32'd1);
        chk("endrop_got1", 32'(got1 - g1), 32'd1);
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("endrop_drain0", 32'(eq0.size()), 32'd0);

        // Asynchronous reset with a full buffer.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'($urandom));
        for (int i = 0; i < 4; i++) tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_valid0", 32'(valid0), 32'd0);
        chk("arst_valid1", 32'(valid1), 32'd0);
        chk("arst_count0", cnt0, 32'd0);
        chk("arst_count1", cnt1, 32'd0);
        chk("arst_idle0", 32'(idle0), 32'd1);
        chk("arst_idle1", 32'(idle1), 32'd1);
        chk("arst_ren0", 32'(ren0), 32'd0);
        chk("arst_ren1", 32'(ren1), 32'd0);
        eq0 = fq0; eq1 = fq1;
        hold0 = 1'b0; hold1 = 1'b0; got0 = 0; got1 = 0;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("arst_resume0", 32'(got0), 32'd3);
        chk("arst_resume1", 32'(got1), 32'd3);
        chk("arst_cnt0", cnt0, 32'(got0));

        // Random traffic, then drain.
        for (int i = 0; i < 400; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) load(8'($urandom));
            tick();
        end
        en = 1'b1; ready = 1'b1; n = 0;
        while ((eq0.size() != 0 || eq1.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        tick(); tick();
        chk("rand_left0", 32'(eq0.size()), 32'd0);
        chk("rand_left1", 32'(eq1.size()), 32'd0);
        chk("rand_count0", cnt0, 32'(got0));
        chk("rand_count1", cnt1, 32'(got1));
        chk("rand_idle0", 32'(idle0), 32'd1);
        chk("rand_idle1", 32'(idle1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's FIFO. Drives the FIFO read enable from the FIFO empty flag and a local credit count, and absorbs the FIFO read latency (FWFT or registered read data).
- Presents the words as a valid/ready stream through a 2-entry output buffer. Sustains 1 word/cycle.
- Sits in the FIFO's read clock domain, between the FIFO read port and the downstream consumer.

Parameters:
- WIDTH, 1, data word width; must match the FIFO.
- FWFT, 0, 1 = FIFO data is valid combinationally at the read pointer; 0 = FIFO data is registered and valid the cycle after ren.
- CNT_WIDTH, 32, width of the transferred-word counter.

Ports:
- i_clk  in  1  clock (same clock as the FIFO read side)
- i_rst  in  1  reset; asynchronous, active-high
- i_en  in  1  prefetch enable; 0 stops new FIFO reads, in-flight words still land
- o_fifo_ren  out  1  FIFO read enable
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_rdata  in  WIDTH  FIFO read data
- o_valid  out  1  output word valid
- i_ready  in  1  downstream ready
- o_data  out  WIDTH  output word (buffer head)
- o_count  out  CNT_WIDTH  number of accepted output transfers
- o_idle  out  1  1 when buffer empty and no read in flight

Behaviour:
- Reset (async assert, released synchronously by the system): buffer occupancy 0, in-flight flag 0, o_valid 0, o_data 0, o_count 0, o_fifo_ren 0 (combinational from cleared state), o_idle 1. Both buffer entries clear to 0.
- Reset mid-operation: discard buffer and in-flight word. No output transfer completes in the reset cycle.
- Internal state:
  - occ: 0..2, buffer occupancy.
  - inflight: 1 bit, FWFT=0 only; equals the previous cycle's o_fifo_ren. Tied 0 for FWFT=1.
- pop = o_valid && i_ready. o_valid = (occ != 0).
- Read issue (combinational): o_fifo_ren = i_en && !i_fifo_empty && (occ + inflight - pop) < 2. Never asserted while i_fifo_empty=1.
- Push:
  - FWFT=1: push in the same cycle as o_fifo_ren, capturing i_fifo_rdata.
  - FWFT=0: push in the cycle after o_fifo_ren (inflight=1), capturing i_fifo_rdata.
  - No push when inflight=0, even if i_fifo_rdata changes.
- Buffer is a FIFO-ordered 2-entry register pair; o_data is always entry 0.
  - Pop only: entry 1 shifts to entry 0.
  - Simultaneous push and pop at occ=1: new word goes directly to entry 0, occ stays 1.
  - At occ=2: pop shifts, and a push writes entry 1.
  - occ never exceeds 2; the credit rule guarantees no push at occ=2 without a pop.
- Latency from o_fifo_ren to o_valid (empty buffer): FWFT=1 → 1 cycle; FWFT=0 → 2 cycles.
- Throughput: i_ready held 1 with the FIFO non-empty gives 1 transfer/cycle in steady state for both FWFT values.
- Backpressure: o_data and o_valid are held stable while o_valid=1 and i_ready=0.
- o_count increments by 1 on each pop and wraps modulo 2^CNT_WIDTH.
- o_idle = (occ == 0) && !inflight.
- i_en deassert: the FWFT=0 in-flight word is still pushed. Buffered words remain available to downstream.

Test Plan:
- WIDTH=8, FWFT=0: FIFO holds 0x11,0x22,0x33, i_ready=1, i_en=1 → o_fifo_ren high 3 cycles starting cycle 0; o_valid high cycles 2–4 with o_data 0x11,0x22,0x33; o_count=3; o_idle returns 1.
- FWFT=1, same data → o_valid cycles 1–3, same order; no o_fifo_ren while i_fifo_empty=1.
- FWFT=0, i_ready=0, FIFO holds 5 words → exactly 2 reads issued, occ=2, o_data=word0 stable. Raise i_ready → words 0–4 delivered in order, with no gaps after the first.
- i_ready toggling 1010…, FIFO holds 20 words (both FWFT) → all 20 words delivered in order, none duplicated or lost, o_count=20.
- i_en dropped in the cycle after o_fifo_ren (FWFT=0) → the in-flight word is still delivered and no further reads occur.
- i_rst pulsed asynchronously mid-stream with occ=2 → o_valid=0, o_count=0, o_idle=1 immediately; after release, streaming resumes from the FIFO's next word.
